// File: rtl/nibble_arb_pkg.sv
// Shared constants, response record and round-robin pick helper for nibble_add_arbiter.
package nibble_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 4;
    localparam int unsigned ID_W_DEF    = $clog2(NUM_REQ_DEF);
    localparam int unsigned MAX_REQ     = 8;

    typedef struct packed {
        logic                  carry;
        logic [DATA_W_DEF-1:0] sum;
        logic [ID_W_DEF-1:0]   id;
    } rsp_t;

    // Returns {found, index}: first set bit of valid searching ptr, ptr+1, ... mod num.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int unsigned        num);
        logic        found;
        logic [2:0]  idx;
        int unsigned j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < num) begin
                j = (32'(ptr) + i) % num;
                if (!found && valid[j[2:0]]) begin
                    found = 1'b1;
                    idx   = j[2:0];
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/nibble_add_arbiter_rr.sv
// Round-robin arbiter: pointer register plus combinational priority pick starting at the pointer.
module rr_arbiter
    import nibble_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_slot_free,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [3:0]         w_pick;
    logic [ID_W-1:0]    w_win;
    logic               w_fire;
    logic [ID_W-1:0]    r_ptr;

    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_REQ-1:0]   = i_valid;
        w_pick                     = rr_pick(w_valid_ext, 3'(r_ptr), NUM_REQ);
        w_win                      = w_pick[ID_W-1:0];
        o_grant                    = '0;
        if (w_pick[3] && i_slot_free && !i_reset) begin
            o_grant[w_win] = 1'b1;
        end
    end

    assign o_grant_id = w_win;
    assign w_fire     = |o_grant;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (32'(w_win) == NUM_REQ - 1) ? '0 : w_win + ID_W'(1);
        end
    end

endmodule

// File: rtl/nibble_add_arbiter.sv
// Shares one registered adder among NUM_REQ requesters via round-robin arbitration.
// Define ARB_STALL_STATS_EN to add the saturating o_stall_cnt backpressure counter.
module nibble_add_arbiter
    import nibble_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_sum,
    output logic                      o_rsp_carry,
    output logic [ID_W-1:0]           o_rsp_id,
`ifdef ARB_STALL_STATS_EN
    output logic [7:0]                o_stall_cnt,
`endif
    output logic                      o_busy
);

    logic              w_slot_free;
    logic              w_accept;
    logic [ID_W-1:0]   w_grant_id;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W:0]   w_sum_full;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_sum;
    logic              r_rsp_carry;
    logic [ID_W-1:0]   r_rsp_id;

    // A draining response frees the slot in the same cycle, so results stream without bubbles.
    assign w_slot_free = !r_rsp_valid || i_rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_req_valid),
        .i_slot_free (w_slot_free),
        .o_grant     (o_req_ready),
        .o_grant_id  (w_grant_id)
    );

    assign w_accept   = |o_req_ready;
    assign w_op_a     = i_req_a[w_grant_id*DATA_W +: DATA_W];
    assign w_op_b     = i_req_b[w_grant_id*DATA_W +: DATA_W];
    assign w_sum_full = {1'b0, w_op_a} + {1'b0, w_op_b};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_id    <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum_full[DATA_W-1:0];
            r_rsp_carry <= w_sum_full[DATA_W];
            r_rsp_id    <= w_grant_id;
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ARB_STALL_STATS_EN
    logic [7:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (r_rsp_valid && !i_rsp_ready && r_stall_cnt != 8'hFF) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_carry = r_rsp_carry;
    assign o_rsp_id    = r_rsp_id;
    assign o_busy      = r_rsp_valid || (|i_req_valid);

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Scoreboard bench for nibble_add_arbiter: a round-robin reference model predicts grants and results.
module tb_nibble_add_arbiter;
    import nibble_arb_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_sum;
    logic          rsp_carry;
    logic [1:0]    rsp_id;
    logic          busy;
`ifdef ARB_STALL_STATS_EN
    logic [7:0]    stall_cnt;
    int unsigned   m_stall;
`endif

    nibble_add_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_carry (rsp_carry),
        .o_rsp_id    (rsp_id),
`ifdef ARB_STALL_STATS_EN
        .o_stall_cnt (stall_cnt),
`endif
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    rsp_t        sb[$];
    int unsigned m_ptr = 0;
    logic [N-1:0] granted = '0;
    logic        exp_v;
    logic        slot_free;
    logic        found;
    int unsigned win;
    logic [N-1:0] exp_ready;
    logic [W:0]  full;
    rsp_t        ent;

    always @(negedge clk) begin
        exp_v = (sb.size() != 0);
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
        check("busy", {31'd0, busy}, {31'd0, exp_v || (|req_valid)});
`ifdef ARB_STALL_STATS_EN
        check("stall_cnt", {24'd0, stall_cnt}, m_stall);
        if (reset) m_stall = 0;
        else if (exp_v && !rsp_ready && m_stall != 255) m_stall++;
`endif
        if (exp_v) begin
            check("rsp_sum", {28'd0, rsp_sum}, {28'd0, sb[0].sum});
            check("rsp_carry", {31'd0, rsp_carry}, {31'd0, sb[0].carry});
            check("rsp_id", {30'd0, rsp_id}, {30'd0, sb[0].id});
            if (rsp_ready) void'(sb.pop_front());
        end
        slot_free = !exp_v || rsp_ready;
        found = 1'b0;
        win = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req_valid[(m_ptr + k) % N]) begin
                found = 1'b1;
                win = (m_ptr + k) % N;
            end
        end
        exp_ready = (!reset && found && slot_free) ? (N'(1) << win) : '0;
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
        granted = exp_ready;
        if (reset) begin
            sb.delete();
            m_ptr = 0;
        end else if (exp_ready != '0) begin
            full = {1'b0, req_a[win*W +: W]} + {1'b0, req_b[win*W +: W]};
            ent.carry = full[W];
            ent.sum = full[W-1:0];
            ent.id = 2'(win);
            sb.push_back(ent);
            m_ptr = (win + 1) % N;
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic rdy, input logic rst);
        @(posedge clk);
        #1;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
        reset     = rst;
    endtask

    logic [N-1:0]   cur_v;
    logic [N*W-1:0] cur_a;
    logic [N*W-1:0] cur_b;

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
`ifdef ARB_STALL_STATS_EN
        m_stall = 0;
`endif
        step('0, '0, '0, 1'b1, 1'b1);
        step('0, '0, '0, 1'b1, 1'b0);
        // Reset arrives the cycle after req0 (9+9) is accepted
        step(4'b0001, 16'h0009, 16'h0009, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b1);
        step(4'b0011, 16'h0011, 16'h0011, 1'b1, 1'b1);
        step('0, '0, '0, 1'b1, 1'b0);
        // Single request and overflow
        step(4'b0100, 16'h0300, 16'h0400, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        step(4'b0010, 16'h00F0, 16'h0020, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        // Pointer back to 0, then all four requesters valid
        step('0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1111, 16'h4321, 16'h1111, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        // Backpressure on an id=3 sum=A response, then release with simultaneous drain+accept
        step(4'b1000, 16'h4000, 16'h6000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b1111, 16'h4321, 16'h1111, 1'b0, 1'b0);
        step(4'b1111, 16'h4321, 16'h1111, 1'b1, 1'b0);
        step(4'b0001, 16'h0001, 16'h0001, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        // Random traffic; each requester holds its operands until granted
        cur_v = '0;
        cur_a = '0;
        cur_b = '0;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!cur_v[i] || granted[i]) begin
                    cur_v[i] = 1'($urandom_range(0, 1));
                    cur_a[i*W +: W] = W'($urandom_range(0, 15));
                    cur_b[i*W +: W] = W'($urandom_range(0, 15));
                end
            end
            step(cur_v, cur_a, cur_b, 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
